l1_refill: RTL and testbench
============================

# l1_refill

Miss-handling fill engine for the N-port L1 block cache: the write side of the cache's read-only lookup ports. It takes miss requests from up to PORTS requesters and arbitrates them round-robin. For each granted miss it fetches the block from the chunk store over a valid/ready request and valid-only response interface, then writes the result into one cache entry, chosen by a cyclic victim pointer. It sits between the cache's per-port `valid` outputs and chunk BRAM, and drives the cache's fill port.

## Interface
- PORTS, default 4: number of miss requesters; matches cache port count.
- CACHE_SIZE, default 16: cache entries; any value ≥ 2, not necessarily a power of two.
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, asynchronous, active-low.
- miss_valid, input, [PORTS-1:0]: per-port miss pending. The requester holds it, with a stable address, until miss_done or until it withdraws.
- miss_addr, input, BlockPos [PORTS-1:0]: missed block position per port.
- miss_done, output, [PORTS-1:0]: one-cycle pulse; the fill for that port's address has been written.
- mem_req_valid, output, 1: chunk-store read request.
- mem_req_ready, input, 1: chunk store accepts the request.
- mem_req_addr, output, BlockPos: requested position.
- mem_resp_valid, input, 1: read data valid. There is one response per accepted request.
- mem_resp_data, input, BlockType: returned block.
- fill_en, output, 1: write strobe into the cache.
- fill_idx, output, $clog2(CACHE_SIZE): victim entry index.
- fill_tag, output, BlockPos: tag to write.
- fill_data, output, BlockType: block to write.
- busy, output, 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE. The engine allows one outstanding fill at a time.
- **IDLE**
  - If any miss_valid bit is set, grant the first set bit at or after rr_ptr, scanning upward with wrap from PORTS-1 to 0.
  - Latch the grant index and miss_addr, then go to REQ.
  - If the latched address equals the invalid-tag pattern (every coordinate at its most-negative value), skip the fetch and go straight to WRITE with fill_en suppressed.
- **REQ**
  - mem_req_valid = 1 and mem_req_addr = latched address; both stay stable until mem_req_ready.
  - On ready, go to WAIT.
  - mem_resp_valid is ignored in this state.
- **WAIT**
  - On mem_resp_valid, capture mem_resp_data and go to WRITE.
  - The engine waits indefinitely; there is no timeout.
- **WRITE**, held for one cycle:
  - fill_en = 1, fill_idx = victim, fill_tag = latched address, fill_data = captured data.
  - Pulse miss_done for the granted port, but only if its miss_valid is still high and miss_addr still matches. A withdrawn miss still fills, with no done pulse.
  - victim increments, wrapping from CACHE_SIZE-1 to 0.
  - rr_ptr becomes grant+1, wrapping from PORTS-1 to 0.
  - Go to IDLE.
- Invalid-tag request: WRITE keeps fill_en = 0, victim is not advanced, and miss_done pulses as normal.
- New miss_valid assertions during REQ/WAIT/WRITE are not sampled. They are arbitrated on the next IDLE cycle.
- mem_resp_valid arriving in IDLE or WRITE is discarded. This covers stale responses after a reset.

## Timing
- All outputs are registered.
- Reset values:
  - FSM in IDLE; victim = 0; rr_ptr = 0.
  - mem_req_valid, fill_en, miss_done and busy all 0.
  - mem_req_addr, fill_tag and fill_idx all 0.
  - fill_data = BLOCK_AIR.
- Minimum latency: miss_valid sampled in IDLE at edge 0 → mem_req_valid from edge 1 → (ready same cycle) WAIT from edge 2 → (resp same cycle) fill_en/miss_done at edge 3 → IDLE at edge 4.
  - Back-to-back fills therefore have a 4-cycle minimum period.
- The cache sees the new entry on the cycle after fill_en. Requester lookups hit one cycle after that.
- Reset mid-operation: the FSM returns to IDLE immediately and asynchronously.
  - mem_req_valid drops without waiting for ready.
  - Any pending response is dropped per the IDLE rule.

## Configuration
- L1_REFILL_COALESCE_EN:
  - **Defined:** in WRITE, miss_done pulses for every port with miss_valid high and miss_addr equal to fill_tag, not only the granted port.
  - **Undefined:** only the granted port is pulsed. Other ports waiting on the same address see a cache hit and must withdraw on their own.
  - fill behaviour is identical in both modes.

## Structure
- Shared package (types.sv) holds:
  - BlockPos, BlockType, BLOCK_AIR and `CHUNK_WIDTH.
  - A new TAG_INVALID localparam, which this block and the cache both use for the invalid-tag pattern.
- Sub-module: rr_arbiter (PORTS-wide request vector plus pointer in, one-hot grant and index out), purely combinational and reusable.

## Test plan
- **Single miss:** port 2 misses at (1,-3,5); ready/resp in the same cycle. Expect a fill at edge 3 with fill_idx=0 and fill_tag=(1,-3,5), miss_done=4'b0100, and busy low at edge 4.
- **Round-robin:** all 4 ports miss at distinct addresses, held. Expect grants in order 0,1,2,3, fill_idx 0,1,2,3, and one done pulse per port.
- **Victim wrap:** 17 sequential fills with CACHE_SIZE=16. The 17th fill_idx is 0.
- **Backpressure/latency:** hold mem_req_ready low for 5 cycles, then resp 7 cycles later. Expect mem_req_valid and mem_req_addr stable throughout, and exactly one fill.
- **Coalesce:** ports 0 and 3 miss on the same address. With the macro defined, miss_done=4'b1001 in one cycle; without it, 4'b0001.
- **Reset/invalid:** assert rst_in low while in WAIT, then send mem_resp_valid after release. Expect no fill and all outputs at their reset values. A miss at the TAG_INVALID address pulses miss_done with fill_en=0 and victim unchanged.

Source files
------------

// File: rtl/l1_refill_pkg.sv
// rtl/l1_refill_pkg.sv - block/tag types, invalid-tag pattern and FSM encoding shared by the L1 fill engine and cache
`ifndef CHUNK_WIDTH
`define CHUNK_WIDTH 16
`endif

package l1_refill_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } BlockPos;

  typedef logic [7:0] BlockType;

  localparam BlockType BLOCK_AIR = 8'h00;

  // Every coordinate at its most-negative value marks an empty cache tag.
  localparam logic [COORD_W-1:0] COORD_MIN = {1'b1, {(COORD_W-1){1'b0}}};
  localparam BlockPos TAG_INVALID = {COORD_MIN, COORD_MIN, COORD_MIN};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} refill_state_e;

  function automatic logic is_tag_invalid(input BlockPos p);
    return p == TAG_INVALID;
  endfunction

endpackage

// File: rtl/l1_refill_rr_arbiter.sv
// rtl/l1_refill_rr_arbiter.sv - combinational round-robin arbiter: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from the farthest slot down so the nearest one to ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/l1_refill.sv
// rtl/l1_refill.sv - L1 cache miss fill engine; define L1_REFILL_COALESCE_EN to complete every waiter on the filled address
module l1_refill
  import l1_refill_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int CACHE_SIZE = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [PORTS-1:0]              miss_valid,
  input  BlockPos [PORTS-1:0]           miss_addr,
  output logic [PORTS-1:0]              miss_done,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output BlockPos                       mem_req_addr,
  input  logic                          mem_resp_valid,
  input  BlockType                      mem_resp_data,
  output logic                          fill_en,
  output logic [$clog2(CACHE_SIZE)-1:0] fill_idx,
  output BlockPos                       fill_tag,
  output BlockType                      fill_data,
  output logic                          busy
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int IW = $clog2(CACHE_SIZE);

  refill_state_e    state_q, state_d;
  logic [PW-1:0]    grant_q, grant_d;
  BlockPos          addr_q, addr_d;
  logic [IW-1:0]    victim_q, victim_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  BlockPos          mem_req_addr_q, mem_req_addr_d;
  logic             fill_en_q, fill_en_d;
  logic [IW-1:0]    fill_idx_q, fill_idx_d;
  BlockPos          fill_tag_q, fill_tag_d;
  BlockType         fill_data_q, fill_data_d;
  logic [PORTS-1:0] miss_done_q, miss_done_d;
  logic             busy_q, busy_d;

  logic [PORTS-1:0] arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;

  BlockPos          done_tag;
  logic [PW-1:0]    done_port;
  logic [PORTS-1:0] done_vec;
  logic [IW-1:0]    victim_next;
  logic [PW-1:0]    rr_next;

  rr_arbiter #(.N(PORTS), .PW(PW)) u_arb (
    .req   (miss_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_any = |arb_grant;

  // The done mask is formed one cycle ahead so it lands in the WRITE cycle.
  always_comb begin
    done_tag  = (state_q == IDLE) ? miss_addr[arb_idx] : addr_q;
    done_port = (state_q == IDLE) ? arb_idx : grant_q;
    done_vec  = '0;
    for (int p = 0; p < PORTS; p++) begin
`ifdef L1_REFILL_COALESCE_EN
      done_vec[p] = miss_valid[p] && (miss_addr[p] == done_tag);
`else
      done_vec[p] = miss_valid[p] && (miss_addr[p] == done_tag) && (PW'(p) == done_port);
`endif
    end
  end

  always_comb begin
    victim_next = (victim_q == IW'(CACHE_SIZE - 1)) ? '0 : victim_q + 1'b1;
    rr_next     = (done_port == PW'(PORTS - 1)) ? '0 : done_port + 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    addr_d          = addr_q;
    victim_d        = victim_q;
    rr_ptr_d        = rr_ptr_q;
    mem_req_valid_d = 1'b0;
    mem_req_addr_d  = mem_req_addr_q;
    fill_en_d       = 1'b0;
    fill_idx_d      = fill_idx_q;
    fill_tag_d      = fill_tag_q;
    fill_data_d     = fill_data_q;
    miss_done_d     = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          addr_d  = miss_addr[arb_idx];
          if (is_tag_invalid(miss_addr[arb_idx])) begin
            state_d     = WRITE;
            fill_idx_d  = victim_q;
            fill_tag_d  = miss_addr[arb_idx];
            miss_done_d = done_vec;
            rr_ptr_d    = rr_next;
          end else begin
            state_d         = REQ;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = miss_addr[arb_idx];
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d     = WRITE;
          fill_en_d   = 1'b1;
          fill_idx_d  = victim_q;
          fill_tag_d  = addr_q;
          fill_data_d = mem_resp_data;
          miss_done_d = done_vec;
          victim_d    = victim_next;
          rr_ptr_d    = rr_next;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      addr_q          <= '0;
      victim_q        <= '0;
      rr_ptr_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      fill_en_q       <= 1'b0;
      fill_idx_q      <= '0;
      fill_tag_q      <= '0;
      fill_data_q     <= BLOCK_AIR;
      miss_done_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      addr_q          <= addr_d;
      victim_q        <= victim_d;
      rr_ptr_q        <= rr_ptr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      fill_en_q       <= fill_en_d;
      fill_idx_q      <= fill_idx_d;
      fill_tag_q      <= fill_tag_d;
      fill_data_q     <= fill_data_d;
      miss_done_q     <= miss_done_d;
      busy_q          <= busy_d;
    end
  end

  assign miss_done     = miss_done_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign fill_en       = fill_en_q;
  assign fill_idx      = fill_idx_q;
  assign fill_tag      = fill_tag_q;
  assign fill_data     = fill_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_l1_refill.sv
// tb/tb_l1_refill.sv - directed self-checking bench for l1_refill (PORTS=4, CACHE_SIZE=16)
module tb_l1_refill;
  import l1_refill_pkg::*;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [3:0]    miss_valid;
  BlockPos [3:0] miss_addr;
  logic [3:0]    miss_done;
  logic          mem_req_valid;
  logic          mem_req_ready;
  BlockPos       mem_req_addr;
  logic          mem_resp_valid;
  BlockType      mem_resp_data;
  logic          fill_en;
  logic [3:0]    fill_idx;
  BlockPos       fill_tag;
  BlockType      fill_data;
  logic          busy;

  l1_refill #(.PORTS(4), .CACHE_SIZE(16)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_done      (miss_done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .fill_en        (fill_en),
    .fill_idx       (fill_idx),
    .fill_tag       (fill_tag),
    .fill_data      (fill_data),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic BlockPos mk(input int x, input int y, input int z);
    BlockPos p;
    p.x = COORD_W'(x);
    p.y = COORD_W'(y);
    p.z = COORD_W'(z);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic wait_fill(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fill_en && n < 30);
    check({tag, "_seen"}, 64'(fill_en), 64'd1);
  endtask

  task automatic do_reset();
    rst_in         = 1'b0;
    miss_valid     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, 64'({mem_req_valid, fill_en, miss_done, busy}), 64'd0);
    check({tag, "_req_addr"}, 64'(mem_req_addr), 64'd0);
    check({tag, "_tag_idx"}, 64'({fill_tag, fill_idx}), 64'd0);
    check({tag, "_data"}, 64'(fill_data), 64'(BLOCK_AIR));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int      n;
    int      idx_log [17];
    BlockPos rr_addr [4];
    BlockPos p;
    logic [3:0] exp_done;

    miss_addr     = '0;
    mem_resp_data = 8'h00;
    do_reset();
    check_reset_outs("reset");

    // single miss, ready and response same cycle
    p = mk(1, -3, 5);
    miss_addr[2]   = p;
    miss_valid     = 4'b0100;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 8'h2A;
    tick();
    check("single_req", 64'({mem_req_valid, busy}), 64'b11);
    check("single_req_addr", 64'(mem_req_addr), 64'(p));
    tick();
    check("single_wait", 64'({mem_req_valid, fill_en}), 64'b00);
    tick();
    check("single_fill", 64'({fill_en, fill_idx}), 64'h10);
    check("single_tag", 64'(fill_tag), 64'(p));
    check("single_data", 64'(fill_data), 64'h2A);
    check("single_done", 64'(miss_done), 64'b0100);
    miss_valid = '0;
    tick();
    check("single_idle", 64'({busy, fill_en, miss_done}), 64'd0);

    // round-robin with all ports held
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rr_addr[k]   = mk(10 + k, -k, 2 * k);
      miss_addr[k] = rr_addr[k];
    end
    miss_valid     = 4'b1111;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_fill("rr", n);
      check("rr_period", 64'(n), (k == 0) ? 64'd3 : 64'd4);
      check("rr_tag", 64'(fill_tag), 64'(rr_addr[k]));
      check("rr_idx", 64'(fill_idx), 64'(k));
      check("rr_done", 64'(miss_done), 64'(4'b0001 << k));
      miss_valid[k] = 1'b0;
    end
    tick();

    // victim pointer wrap over 17 fills
    do_reset();
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      miss_addr[0] = mk(i, 7, 0);
      miss_valid   = 4'b0001;
      wait_fill("wrap", n);
      idx_log[i] = int'(fill_idx);
      miss_valid = '0;
    end
    tick();
    check("wrap_idx1", 64'(idx_log[1]), 64'd1);
    check("wrap_idx15", 64'(idx_log[15]), 64'd15);
    check("wrap_idx16", 64'(idx_log[16]), 64'd0);

    // backpressure on request, slow response, stray response during REQ
    do_reset();
    p = mk(-100, 3, 99);
    miss_addr[1]  = p;
    miss_valid    = 4'b0010;
    tick();
    check("bp_req", 64'(mem_req_valid), 64'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", 64'({mem_req_valid, fill_en}), 64'b10);
      check("bp_addr", 64'(mem_req_addr), 64'(p));
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    check("bp_accept", 64'(mem_req_valid), 64'd0);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_wait", 64'({mem_req_valid, fill_en, busy}), 64'b001);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 8'h55;
    tick();
    mem_resp_valid = 1'b0;
    check("bp_fill", 64'({fill_en, fill_idx}), 64'h10);
    check("bp_data", 64'(fill_data), 64'h55);
    check("bp_done", 64'(miss_done), 64'b0010);
    miss_valid = '0;
    tick();
    check("bp_single", 64'(fill_en), 64'd0);

    // two ports waiting on the same address
    do_reset();
    p = mk(4, 4, -4);
    miss_addr[0] = p;
    miss_addr[3] = p;
    miss_valid   = 4'b1001;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    wait_fill("coal", n);
`ifdef L1_REFILL_COALESCE_EN
    exp_done = 4'b1001;
`else
    exp_done = 4'b0001;
`endif
    check("coal_done", 64'(miss_done), 64'(exp_done));
    miss_valid = '0;
    tick();

    // withdrawn miss still fills but gets no done pulse
    mem_resp_valid = 1'b0;
    miss_addr[2]   = mk(2, 2, 2);
    miss_valid     = 4'b0100;
    tick();
    tick();
    miss_valid     = '0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("wd_fill", 64'({fill_en, fill_idx}), 64'h11);
    check("wd_done", 64'(miss_done), 64'd0);
    tick();

    // async reset while waiting, then a stale response
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    miss_addr[1]   = mk(9, 9, 9);
    miss_valid     = 4'b0010;
    tick();
    tick();
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst_in     = 1'b0;
    miss_valid = '0;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    @(negedge clk_in);
    rst_in         = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 8'h77;
    tick();
    tick();
    check_reset_outs("rst_stale");
    mem_resp_valid = 1'b0;

    // invalid tag: done pulse, no fill, victim not advanced
    miss_addr[0] = TAG_INVALID;
    miss_valid   = 4'b0001;
    tick();
    check("inv_done", 64'(miss_done), 64'b0001);
    check("inv_fill", 64'({fill_en, mem_req_valid}), 64'b00);
    check("inv_tag", 64'(fill_tag), 64'(TAG_INVALID));
    miss_valid = '0;
    tick();
    check("inv_idle", 64'(busy), 64'd0);
    miss_addr[0]   = mk(0, 1, 0);
    miss_valid     = 4'b0001;
    mem_resp_valid = 1'b1;
    wait_fill("inv_next", n);
    check("inv_victim", 64'(fill_idx), 64'd0);
    miss_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
